// File: rtl/dft8_top.sv
// Pipelined 8-point complex DFT (radix-2 DIF, 3 stages, 1/8 overall scaling).
// Define DFT_ROUND_EN to round-half-up every arithmetic shift instead of truncating.
module dft8_top #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             next,
  input  logic [WIDTH-1:0] X0, X1, X2, X3, X4, X5, X6, X7,
  input  logic [WIDTH-1:0] X8, X9, X10, X11, X12, X13, X14, X15,
  output logic             next_out,
  output logic [WIDTH-1:0] Y0, Y1, Y2, Y3, Y4, Y5, Y6, Y7,
  output logic [WIDTH-1:0] Y8, Y9, Y10, Y11, Y12, Y13, Y14, Y15
);
  localparam int W      = WIDTH;
  localparam int STAGES = 3;
  localparam longint CL = longint'(0.7071067811865476 * (2.0 ** (W - 1)));
  localparam logic signed [W:0] C = CL[W:0];

  typedef struct packed {
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
  } cpx_t;

  function automatic logic signed [W:0] sx(input logic signed [W-1:0] a);
    return {a[W-1], a};
  endfunction

  // (a +/- b) >>> 1 on a guard-bit sum; result always fits W bits
  function automatic logic signed [W-1:0] half(input logic signed [W:0] s);
`ifdef DFT_ROUND_EN
    logic signed [W+1:0] t;
    t = {s[W], s} + (W+2)'(1);
    return t[W:1];
`else
    return s[W:1];
`endif
  endfunction

  // C * s >>> (W-1); unsigned multiply of sign-extended operands gives the same low bits
  function automatic logic signed [W-1:0] cmul(input logic signed [W:0] s);
    logic signed [2*W+1:0] p;
    p = {{(W+1){s[W]}}, s} * {{(W+1){C[W]}}, C};
`ifdef DFT_ROUND_EN
    p = p + ((2*W+2)'(1) << (W - 2));
`endif
    return p[2*W-2:W-1];
  endfunction

  function automatic void bfly(input cpx_t a, input cpx_t b, input logic [1:0] e,
                               output cpx_t u, output cpx_t v);
    logic signed [W-1:0] dr, di;
    u.r = half(sx(a.r) + sx(b.r));
    u.i = half(sx(a.i) + sx(b.i));
    dr  = half(sx(a.r) - sx(b.r));
    di  = half(sx(a.i) - sx(b.i));
    case (e)
      2'd0: begin v.r = dr; v.i = di; end
      2'd1: begin v.r = cmul(sx(dr) + sx(di)); v.i = cmul(sx(di) - sx(dr)); end
      2'd2: begin v.r = di; v.i = -dr; end
      default: begin v.r = cmul(sx(di) - sx(dr)); v.i = cmul(-(sx(dr) + sx(di))); end
    endcase
  endfunction

  logic [STAGES:0] vld_pipe;
  cpx_t [7:0] xin, xq, s1d, s1q, s2d, s2q, s3d, yd, yq;
  logic [2:0] kk;

  always_comb begin
    xin[0] = '{r: X0,  i: X1};
    xin[1] = '{r: X2,  i: X3};
    xin[2] = '{r: X4,  i: X5};
    xin[3] = '{r: X6,  i: X7};
    xin[4] = '{r: X8,  i: X9};
    xin[5] = '{r: X10, i: X11};
    xin[6] = '{r: X12, i: X13};
    xin[7] = '{r: X14, i: X15};
  end

  always_comb begin
    s1d = '0;
    for (int n = 0; n < 4; n++) bfly(xq[n], xq[n+4], 2'(n), s1d[n], s1d[n+4]);
  end

  always_comb begin
    s2d = '0;
    for (int g = 0; g < 8; g += 4)
      for (int n = 0; n < 2; n++)
        bfly(s1q[g+n], s1q[g+n+2], 2'(2*n), s2d[g+n], s2d[g+n+2]);
  end

  // last stage plus bit-reversal feeds the output register directly
  always_comb begin
    s3d = '0;
    yd  = '0;
    kk  = '0;
    for (int g = 0; g < 8; g += 2) bfly(s2q[g], s2q[g+1], 2'd0, s3d[g], s3d[g+1]);
    for (int k = 0; k < 8; k++) begin
      kk    = 3'(k);
      yd[k] = s3d[{kk[0], kk[1], kk[2]}];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      xq       <= '0;
      s1q      <= '0;
      s2q      <= '0;
      yq       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], next};
      if (vld_pipe[0]) xq  <= xin;
      if (vld_pipe[1]) s1q <= s1d;
      if (vld_pipe[2]) s2q <= s2d;
      if (vld_pipe[3]) yq  <= yd;
    end
  end

  assign next_out = vld_pipe[STAGES];

  assign Y0  = yq[0].r;  assign Y1  = yq[0].i;
  assign Y2  = yq[1].r;  assign Y3  = yq[1].i;
  assign Y4  = yq[2].r;  assign Y5  = yq[2].i;
  assign Y6  = yq[3].r;  assign Y7  = yq[3].i;
  assign Y8  = yq[4].r;  assign Y9  = yq[4].i;
  assign Y10 = yq[5].r;  assign Y11 = yq[5].i;
  assign Y12 = yq[6].r;  assign Y13 = yq[6].i;
  assign Y14 = yq[7].r;  assign Y15 = yq[7].i;
endmodule

// File: tb/tb_dft8_top.sv
// Directed-vector and float-model bench for dft8_top (default build, truncating shifts).
module tb_dft8_top;
  logic        clk = 1'b0;
  logic        reset;
  logic        next;
  logic        next_out;
  logic [15:0] xv [16];
  logic [15:0] yv [16];

  always #5 clk = ~clk;

  dft8_top #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .next(next),
    .X0(xv[0]),   .X1(xv[1]),   .X2(xv[2]),   .X3(xv[3]),
    .X4(xv[4]),   .X5(xv[5]),   .X6(xv[6]),   .X7(xv[7]),
    .X8(xv[8]),   .X9(xv[9]),   .X10(xv[10]), .X11(xv[11]),
    .X12(xv[12]), .X13(xv[13]), .X14(xv[14]), .X15(xv[15]),
    .next_out(next_out),
    .Y0(yv[0]),   .Y1(yv[1]),   .Y2(yv[2]),   .Y3(yv[3]),
    .Y4(yv[4]),   .Y5(yv[5]),   .Y6(yv[6]),   .Y7(yv[7]),
    .Y8(yv[8]),   .Y9(yv[9]),   .Y10(yv[10]), .Y11(yv[11]),
    .Y12(yv[12]), .Y13(yv[13]), .Y14(yv[14]), .Y15(yv[15])
  );

  typedef struct {
    string       nm;
    logic [15:0] x [16];
    logic [15:0] y [16];
  } vec_t;

  vec_t        tv [5];
  logic [15:0] fr [16];
  real         er [16];
  int          npass = 0;
  int          ntot  = 0;

  task automatic chk(input string nm, input int j, input logic [15:0] act, input logic [15:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, j, act, exp);
  endtask

  task automatic chk_near(input string nm, input int j, input logic [15:0] act, input real exp);
    real d;
    ntot++;
    d = real'($signed(act)) - exp;
    if (d <= 2.0 && d >= -2.0) npass++;
    else $display("FAIL %s[%0d]: got %0d expected %0f (+/-2)", nm, j, $signed(act), exp);
  endtask

  task automatic chk_y_zero(input string nm);
    for (int j = 0; j < 16; j++) chk(nm, j, yv[j], 16'h0000);
  endtask

  // next pulse, frame in following cycle, then expect next_out 4 negedges later and Y one edge after
  task automatic send();
    int cnt;
    bit got;
    @(posedge clk); #1 next = 1'b1;
    @(posedge clk); #1 next = 1'b0;
    for (int j = 0; j < 16; j++) xv[j] = fr[j];
    cnt = 0;
    got = 1'b0;
    while (cnt < 10 && !got) begin
      @(negedge clk);
      cnt++;
      if (next_out) got = 1'b1;
    end
    chk("latency", 0, 16'(cnt), 16'd4);
    for (int j = 0; j < 16; j++) xv[j] = 16'h1234;
    @(negedge clk);
    chk("pulse_len", 0, {15'd0, next_out}, 16'd0);
  endtask

  task automatic model();
    for (int k = 0; k < 8; k++) begin
      real re, im, a;
      re = 0.0;
      im = 0.0;
      for (int n = 0; n < 8; n++) begin
        a  = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        re = re + real'($signed(fr[2*n])) * $cos(a) + real'($signed(fr[2*n+1])) * $sin(a);
        im = im + real'($signed(fr[2*n+1])) * $cos(a) - real'($signed(fr[2*n])) * $sin(a);
      end
      er[2*k]   = re / 8.0;
      er[2*k+1] = im / 8.0;
    end
  endtask

  initial begin
    for (int v = 0; v < 5; v++)
      for (int j = 0; j < 16; j++) begin
        tv[v].x[j] = 16'h0000;
        tv[v].y[j] = 16'h0000;
      end
    tv[0].nm = "impulse";
    tv[0].x[0] = 16'h4000;
    for (int k = 0; k < 8; k++) tv[0].y[2*k] = 16'h0800;
    tv[1].nm = "dc";
    for (int k = 0; k < 8; k++) tv[1].x[2*k] = 16'h0800;
    tv[1].y[0] = 16'h0800;
    tv[2].nm = "nyquist";
    for (int k = 0; k < 8; k++) tv[2].x[2*k] = (k % 2 == 0) ? 16'h0800 : 16'hF800;
    tv[2].y[8] = 16'h0800;
    tv[3].nm = "imag_dc";
    for (int k = 0; k < 8; k++) tv[3].x[2*k+1] = 16'h0800;
    tv[3].y[1] = 16'h0800;
    // x[2] = 0x4000 -> X[k] = 0x0800 * (-j)^k, exercises the -j twiddle and reordering
    tv[4].nm = "impulse2";
    tv[4].x[4] = 16'h4000;
    for (int k = 0; k < 8; k++)
      case (k % 4)
        0: tv[4].y[2*k]   = 16'h0800;
        1: tv[4].y[2*k+1] = 16'hF800;
        2: tv[4].y[2*k]   = 16'hF800;
        default: tv[4].y[2*k+1] = 16'h0800;
      endcase

    reset = 1'b0;
    next  = 1'b0;
    for (int j = 0; j < 16; j++) xv[j] = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_next_out", 0, {15'd0, next_out}, 16'd0);
    chk_y_zero("rst_y");
    @(posedge clk); #1 reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 16; j++) fr[j] = tv[v].x[j];
      send();
      for (int j = 0; j < 16; j++) chk(tv[v].nm, j, yv[j], tv[v].y[j]);
    end

    // back-to-back impulse then dc
    @(posedge clk); #1 next = 1'b1;
    @(posedge clk); #1 for (int j = 0; j < 16; j++) xv[j] = tv[0].x[j];
    @(posedge clk); #1 next = 1'b0;
    for (int j = 0; j < 16; j++) xv[j] = tv[1].x[j];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("b2b_next_out", c, {15'd0, next_out}, (c == 2 || c == 3) ? 16'd1 : 16'd0);
      if (c == 1) for (int j = 0; j < 16; j++) xv[j] = 16'h5555;
      if (c == 3) for (int j = 0; j < 16; j++) chk("b2b_first", j, yv[j], tv[0].y[j]);
      if (c == 4) for (int j = 0; j < 16; j++) chk("b2b_second", j, yv[j], tv[1].y[j]);
    end

    // reset one cycle after the frame is captured
    @(posedge clk); #1 next = 1'b1;
    @(posedge clk); #1 next = 1'b0;
    for (int j = 0; j < 16; j++) xv[j] = tv[0].x[j];
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("midrst_next_out", c, {15'd0, next_out}, 16'd0);
    end
    chk_y_zero("midrst_y");

    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < 16; j++) fr[j] = 16'($urandom_range(0, 32766)) - 16'd16383;
      model();
      send();
      for (int j = 0; j < 16; j++) chk_near("random", j, yv[j], er[j]);
    end
    for (int j = 0; j < 16; j++) xv[j] = 16'($urandom);
    repeat (5) @(negedge clk);
    chk("idle_next_out", 0, {15'd0, next_out}, 16'd0);
    for (int j = 0; j < 16; j++) chk_near("hold", j, yv[j], er[j]);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
